jk_bank_arbiter: RTL and testbench

//  Shares one bank of WIDTH master-slave JK flip-flops between N_REQ requesters.

---
 rtl/jk_bank_arbiter.sv | 160 ++++++++++++++++
 tb/tb_jk_bank_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_bank_arbiter.sv
// Round-robin arbiter sharing one bank of master-slave JK flip-flops; one command per 3 cycles,
// req sampled at grant edge E0, q/done after E2; requests arriving while busy wait for IDLE.
module jk_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [2*N_REQ-1:0]       cmd,
  input  logic [WIDTH*N_REQ-1:0]   mask,
  output logic [N_REQ-1:0]         gnt,
  output logic                     busy,
  output logic                     done,
  output logic [WIDTH-1:0]         q
);

  localparam int PTR_W = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              arb_go;
  logic              capture_go;
  logic              commit_go;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_nxt;
  logic [PTR_W-1:0]  winner;
  logic [PTR_W-1:0]  idx;
  logic [PTR_W:0]    idx_sum;
  logic              found;

  logic [1:0]        cmd_sel;
  logic [WIDTH-1:0]  mask_sel;
  logic [N_REQ-1:0]  gnt_nxt;

  logic [1:0]        cmd_q;
  logic [WIDTH-1:0]  mask_q;
  logic [WIDTH-1:0]  master;
  logic [WIDTH-1:0]  jk_val;
  logic [WIDTH-1:0]  master_nxt;

  // Scan requesters starting at rr_ptr, wrapping past N_REQ-1; first active one wins.
  always_comb begin
    winner  = '0;
    found   = 1'b0;
    idx_sum = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (idx_sum >= (PTR_W+1)'(N_REQ)) begin
        idx_sum = idx_sum - (PTR_W+1)'(N_REQ);
      end
      idx = idx_sum[PTR_W-1:0];
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign rr_nxt = (winner == PTR_W'(N_REQ-1)) ? '0 : winner + PTR_W'(1);

  always_comb begin
    cmd_sel  = '0;
    mask_sel = '0;
    gnt_nxt  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (winner == PTR_W'(i)) begin
        cmd_sel    = cmd[2*i +: 2];
        mask_sel   = mask[WIDTH*i +: WIDTH];
        gnt_nxt[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    arb_go     = 1'b0;
    capture_go = 1'b0;
    commit_go  = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          arb_go    = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        capture_go = 1'b1;
        state_nxt  = COMMIT;
      end
      COMMIT: begin
        commit_go = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // JK truth table on the slave value: {j,k} 00 hold, 01 clear, 10 set, 11 toggle.
  always_comb begin
    jk_val = q;
    case (cmd_q)
      2'b00: jk_val = q;
      2'b01: jk_val = '0;
      2'b10: jk_val = '1;
      2'b11: jk_val = ~q;
      default: jk_val = q;
    endcase
  end

  assign master_nxt = (mask_q & jk_val) | (~mask_q & q);

  // Master only loads in CAPTURE and slave only in COMMIT, so a toggle is applied once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      done   <= 1'b0;
      q      <= '0;
      master <= '0;
      rr_ptr <= '0;
      cmd_q  <= '0;
      mask_q <= '0;
    end else begin
      done <= 1'b0;
      if (arb_go) begin
        cmd_q  <= cmd_sel;
        mask_q <= mask_sel;
        gnt    <= gnt_nxt;
        rr_ptr <= rr_nxt;
      end
      if (capture_go) begin
        master <= master_nxt;
      end
      if (commit_go) begin
        q    <= master;
        done <= 1'b1;
        gnt  <= '0;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Scoreboarded bench: stimulus feeds a command-level reference model, a monitor checks outputs.
module tb_jk_bank_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [2*N-1:0]    cmd;
  logic [W*N-1:0]    mask;
  logic [N-1:0]      gnt;
  logic              busy;
  logic              done;
  logic [W-1:0]      q;

  jk_bank_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .cmd   (cmd),
    .mask  (mask),
    .gnt   (gnt),
    .busy  (busy),
    .done  (done),
    .q     (q)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    int           w;
    logic [W-1:0] q;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           errors = 0;

  // Reference model: a granted command occupies three edges, result visible after the third.
  int           m_busy;
  int           m_rr;
  logic [W-1:0] m_q;
  logic [W-1:0] m_q_vis;
  logic [N-1:0] m_gnt;
  logic         m_done;
  logic [N-1:0] last_gnt;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp_v, $time);
    end
  endfunction

  task automatic model_reset();
    m_busy  = 0;
    m_rr    = 0;
    m_q     = '0;
    m_q_vis = '0;
    m_gnt   = '0;
    m_done  = 1'b0;
    sb.delete();
  endtask

  // Predicts the effect of the coming rising edge from the inputs currently driven.
  task automatic model_edge();
    int           w;
    logic [1:0]   c;
    logic [W-1:0] mk;
    logic [W-1:0] nq;
    exp_t         e;
    m_done = 1'b0;
    if (!rst_n) return;
    if (m_busy > 0) begin
      m_busy--;
      if (m_busy == 0) begin
        m_done  = 1'b1;
        m_gnt   = '0;
        m_q_vis = m_q;
      end
    end else if (req != '0) begin
      w = -1;
      for (int k = 0; k < N; k++) begin
        if (w < 0 && req[(m_rr + k) % N]) w = (m_rr + k) % N;
      end
      c  = cmd[2*w +: 2];
      mk = mask[W*w +: W];
      nq = m_q;
      for (int b = 0; b < W; b++) begin
        if (mk[b]) begin
          case (c)
            2'b00: nq[b] = m_q[b];
            2'b01: nq[b] = 1'b0;
            2'b10: nq[b] = 1'b1;
            default: nq[b] = ~m_q[b];
          endcase
        end
      end
      e.w = w;
      e.q = nq;
      sb.push_back(e);
      m_q    = nq;
      m_rr   = (w + 1) % N;
      m_busy = 2;
      m_gnt  = N'(1 << w);
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_cmd(int r, logic [1:0] c, logic [W-1:0] m);
    cmd[2*r +: 2]  = c;
    mask[W*r +: W] = m;
  endtask

  // One command from requester r; cmd/mask are scrambled once the grant edge has passed.
  task automatic cmd_one(int r, logic [1:0] c, logic [W-1:0] m);
    req    = '0;
    req[r] = 1'b1;
    set_cmd(r, c, m);
    tick();
    req  = '0;
    cmd  = 8'($urandom);
    mask = 32'($urandom);
    tick();
    tick();
  endtask

  // Monitor: samples 1 time unit after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n) begin
      chk("gnt", 32'(gnt), 32'(m_gnt));
      chk("busy", 32'(busy), 32'(m_busy != 0));
      chk("done", 32'(done), 32'(m_done));
      chk("q", 32'(q), 32'(m_q_vis));
      if (gnt != '0) last_gnt = gnt;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_done actual=1 expected=0 at %0t", $time);
        end else begin
          e = sb.pop_front();
          chk("sb_q", 32'(q), 32'(e.q));
          chk("sb_gnt", 32'(last_gnt), 32'(1 << e.w));
        end
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    cmd      = '0;
    mask     = '0;
    last_gnt = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;
    tick();

    // Reset mid-CAPTURE drops the pending A5 result and clears q.
    cmd_one(0, 2'b10, 8'h5A);
    req = 4'b0001;
    set_cmd(0, 2'b11, 8'hFF);
    tick();
    rst_n = 1'b0;
    req   = '0;
    model_reset();
    #1;
    chk("midrst_q", 32'(q), 32'h0);
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // Single set, then toggle twice without double toggling.
    cmd_one(0, 2'b10, 8'h0F);
    cmd_one(2, 2'b11, 8'hFF);
    cmd_one(2, 2'b11, 8'hFF);
    cmd_one(3, 2'b00, 8'h00);

    // Round robin with all requests held.
    req = 4'b1111;
    repeat (15) begin
      cmd  = 8'($urandom);
      mask = 32'($urandom);
      tick();
    end
    req = '0;
    tick();

    // Clear then hold.
    cmd_one(1, 2'b10, 8'hFF);
    cmd_one(1, 2'b01, 8'h3C);
    cmd_one(1, 2'b00, 8'hFF);

    // Late request raised during COMMIT of requester 0.
    req = 4'b0001;
    set_cmd(0, 2'b10, 8'h01);
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    set_cmd(1, 2'b11, 8'h80);
    tick();
    tick();
    req = '0;
    repeat (3) tick();

    // Random traffic.
    repeat (600) begin
      req  = N'($urandom & $urandom);
      cmd  = 8'($urandom);
      mask = 32'($urandom);
      tick();
    end
    req = '0;
    repeat (5) tick();
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
